data_mem_bytelane: RTL and testbench

- Parametrised successor to the single-port word data memory: byte-addressed, with RV32-style load/store sizes (byte/half/word), signed or unsigned load extension, and byte-lane write masking.
- Valid/ready request and response channels with registered 1-cycle response and backpressure.
- Detects misaligned and out-of-range accesses.
- Sits between the CPU load/store unit and on-chip RAM.

---
 rtl/data_mem_bytelane.sv | 151 +++++++++++++++
 tb/tb_data_mem_bytelane.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bytelane.sv
// data_mem_bytelane: byte-addressed 32-bit data memory that sits between the CPU load/store unit
// and on-chip RAM. It supports RV32 byte, half and word accesses, loads with sign or zero
// extension, and stores with per-lane write masking.
//
// Requests and responses each use a valid/ready handshake. The response is registered, so a
// load returns its data exactly one cycle after the request is accepted, and the block still
// sustains one request per cycle while the consumer keeps up.
//
// Ports:
//   clk, rst       rising-edge clock; asynchronous, active-high reset
//   req_valid      request present
//   req_ready      a request can be accepted this cycle
//   req_we         1 = store, 0 = load
//   req_addr       byte address
//   req_size       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   load extension: 1 = zero-extend, 0 = sign-extend
//   req_wdata      store data, right-justified
//   rsp_valid      response present
//   rsp_ready      consumer accepts the response
//   rsp_rdata      extended load data; 0 for stores and errors
//   rsp_err        misaligned, illegal-size or out-of-range access
module data_mem_bytelane #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IdxW    = ADDR_WIDTH - 2;
  localparam int unsigned MemIdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IdxW-1:0]    word_idx;
  logic [1:0]         lane;
  logic [MemIdxW-1:0] mem_idx;
  logic               acc_err;
  logic               accept;
  logic               mem_we;
  logic [3:0]         be;
  logic [31:0]        wdata_sh;
  logic [31:0]        rd_word;
  logic [31:0]        rd_sh;
  logic [31:0]        load_data;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign lane     = req_addr[1:0];
  // Out-of-range indices are only ever used for masked reads, never for writes.
  assign mem_idx  = MemIdxW'(word_idx);

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;

  // Alignment, size and range checks.
  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = lane[0];
      2'b10:   acc_err = (lane != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if (32'(word_idx) >= DEPTH_WORDS) begin
      acc_err = 1'b1;
    end
  end

  // Lane mask and store data moved into lane position.
  always_comb begin
    be = 4'b0000;
    case (req_size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
  end

  assign wdata_sh = req_wdata << {lane, 3'b000};

  // The register reset never blocks the array, so the write is gated by rst explicitly.
  assign mem_we = accept & req_we & ~acc_err & ~rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) begin
        mem[mem_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Load path: right-justify the addressed lane(s), then extend.
  assign rd_word = mem[mem_idx];
  assign rd_sh   = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   load_data = {{16{~req_unsigned & rd_sh[15]}}, rd_sh[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Response register: load on accept, hold under backpressure, retire on rsp_ready.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (req_we | acc_err) ? 32'd0 : load_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
module tb_data_mem_bytelane;

  localparam int unsigned DepthWords = 512;
  localparam int unsigned AddrWidth  = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_we = 1'b0;
  logic [AddrWidth-1:0] req_addr = '0;
  logic [1:0]           req_size = 2'b00;
  logic                 req_unsigned = 1'b0;
  logic [31:0]          req_wdata = 32'd0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;

  data_mem_bytelane #(
    .DEPTH_WORDS(DepthWords),
    .ADDR_WIDTH (AddrWidth),
    .INIT_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every handshaken response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, then confirm 1-cycle latency.
  task automatic issue(input string name, input logic we, input int addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    logic rdy;
    int   n;
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.name  = name;
    exp_q.push_back(e);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = AddrWidth'(addr);
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    n = 0;
    do begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    req_valid = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got no accept in 50 cycles, expected accept", name);
    end else begin
      check({name, "_lat"}, {31'd0, rsp_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic stores and loads (consecutive store-then-load returns the new data).
    issue("st_w4",    1'b1, 'h004, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    issue("ld_w4",    1'b0, 'h004, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    issue("st_b5",    1'b1, 'h005, 2'b00, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0);
    issue("ld_w4b",   1'b0, 'h004, 2'b10, 1'b0, 32'h0, 32'hDEAD80EF, 1'b0);
    issue("ld_sb5",   1'b0, 'h005, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
    issue("ld_ub5",   1'b0, 'h005, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
    issue("ld_sh6",   1'b0, 'h006, 2'b01, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0);
    issue("ld_uh6",   1'b0, 'h006, 2'b01, 1'b1, 32'h0, 32'h0000DEAD, 1'b0);
    issue("st_h4",    1'b1, 'h004, 2'b01, 1'b1, 32'hABCD1234, 32'h0, 1'b0);
    issue("ld_w4c",   1'b0, 'h004, 2'b10, 1'b0, 32'h0, 32'hDEAD1234, 1'b0);

    // Error cases: no write, rdata 0.
    issue("err_stw6", 1'b1, 'h006, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue("err_ldh3", 1'b0, 'h003, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("err_sz3",  1'b0, 'h000, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("err_oor",  1'b0, 4 * DepthWords, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("err_oorb", 1'b1, 4 * DepthWords + 1, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b1);
    issue("ld_w4d",   1'b0, 'h004, 2'b10, 1'b0, 32'h0, 32'hDEAD1234, 1'b0);

    // Top lane and positive sign extension.
    issue("st_b7",    1'b1, 'h007, 2'b00, 1'b0, 32'h1234567F, 32'h0, 1'b0);
    issue("ld_sb7",   1'b0, 'h007, 2'b00, 1'b0, 32'h0, 32'h0000007F, 1'b0);
    issue("ld_sh6b",  1'b0, 'h006, 2'b01, 1'b0, 32'h0, 32'h00007FAD, 1'b0);
    issue("st_wc",    1'b1, 'h00C, 2'b10, 1'b0, 32'h00000000, 32'h0, 1'b0);
    drain();

    // Backpressure: response held, pending request refused, then no bubble.
    rsp_ready = 1'b0;
    issue("bp_ld",    1'b0, 'h004, 2'b10, 1'b0, 32'h0, 32'h7FAD1234, 1'b0);
    begin
      exp_t e;
      e.rdata = 32'h00000034;
      e.err   = 1'b0;
      e.name  = "bp_pend";
      exp_q.push_back(e);
    end
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_addr     = AddrWidth'('h004);
    req_size     = 2'b00;
    req_unsigned = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_rdata", rsp_rdata, 32'h7FAD1234);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_nobubble_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_nobubble_rdata", rsp_rdata, 32'h00000034);
    drain();

    // Reset with a store response outstanding.
    rsp_ready = 1'b0;
    issue("rst_st",   1'b1, 'h008, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AddrWidth'('h00C);
    req_size  = 2'b10;
    req_wdata = 32'h11111111;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue("rst_ld8",  1'b0, 'h008, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    issue("rst_ldc",  1'b0, 'h00C, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
